// File: rtl/top_stim_pkg.sv
// Shared widths, state encoding and LFSR step for the top_stim_check slice.
package top_stim_pkg;

  localparam int unsigned W_SMALL = 2;
  localparam int unsigned W_QUAD  = 40;
  localparam int unsigned W_WIDE  = 70;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Galois step, taps 32,22,2,1, shifting right
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
  endfunction

endpackage

// File: rtl/top_stim_if.sv
// Stimulus/response bundle between the checker (master) and the datapath under test (slave).
interface top_stim_if;
  import top_stim_pkg::*;

  logic [W_SMALL-1:0] in_small;
  logic [W_QUAD-1:0]  in_quad;
  logic [W_WIDE-1:0]  in_wide;
  logic [W_SMALL-1:0] out_small;
  logic [W_QUAD-1:0]  out_quad;
  logic [W_WIDE-1:0]  out_wide;

  modport master (
    output in_small, in_quad, in_wide,
    input  out_small, out_quad, out_wide
  );

  modport slave (
    input  in_small, in_quad, in_wide,
    output out_small, out_quad, out_wide
  );

endinterface

// File: rtl/top_stim_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance; reset value set by parameter.
module top_stim_lfsr32
  import top_stim_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h1
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] q
);

  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)
      q_d = seed;
    else if (advance)
      q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) q_q <= RESET_VAL;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/top_stim_check.sv
// Drives corner + LFSR vectors into a +1 datapath and checks each response on the following edge.
module top_stim_check
  import top_stim_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        start,
  top_stim_if.master  dut,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        mismatch,
  output logic [15:0] vec_count,
  output logic [15:0] err_count
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  state_e             state_q, state_d;
  logic [15:0]        idx_q, idx_d;
  logic [W_SMALL-1:0] small_q, small_d;
  logic [W_QUAD-1:0]  quad_q, quad_d;
  logic [W_WIDE-1:0]  wide_q, wide_d;
  logic [15:0]        vec_count_q, vec_count_d;
  logic [15:0]        err_count_q, err_count_d;
  logic               mismatch_q, mismatch_d;

  logic        lfsr_load, lfsr_adv;
  logic [31:0] lfsr_q;
  logic        vec_fail;

  top_stim_lfsr32 #(.RESET_VAL(SEED_EFF)) u_lfsr (
    .clk     (clk),
    .reset_l (reset_l),
    .load    (lfsr_load),
    .seed    (SEED_EFF),
    .advance (lfsr_adv),
    .q       (lfsr_q)
  );

  // One failing vector counts once no matter how many ports differ
  assign vec_fail = (dut.out_small != small_q + W_SMALL'(1))
                  | (dut.out_quad  != quad_q  + W_QUAD'(1))
                  | (dut.out_wide  != wide_q  + W_WIDE'(1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    small_d     = small_q;
    quad_d      = quad_q;
    wide_d      = wide_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    mismatch_d  = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          idx_d       = '0;
          small_d     = '0;
          quad_d      = '0;
          wide_d      = '0;
          vec_count_d = '0;
          err_count_d = '0;
          lfsr_load   = 1'b1;
        end
      end
      ST_RUN: begin
        vec_count_d = vec_count_q + 16'd1;
        err_count_d = err_count_q + 16'(vec_fail);
        mismatch_d  = vec_fail;
        idx_d       = idx_q + 16'd1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          small_d = '0;
          quad_d  = '0;
          wide_d  = '0;
        end else if (idx_q == 16'd0) begin
          small_d = '1;
          quad_d  = '1;
          wide_d  = '1;
        end else begin
          // LFSR still holds SEED when vector 2 is loaded; it steps as each LFSR vector is consumed
          small_d  = lfsr_q[1:0];
          quad_d   = {lfsr_q[7:0], lfsr_q};
          wide_d   = {lfsr_q[5:0], lfsr_q, lfsr_q};
          lfsr_adv = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      small_q     <= '0;
      quad_q      <= '0;
      wide_q      <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      small_q     <= small_d;
      quad_q      <= quad_d;
      wide_q      <= wide_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign dut.in_small = small_q;
  assign dut.in_quad  = quad_q;
  assign dut.in_wide  = wide_q;

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_count_q == 16'd0);
  assign mismatch  = mismatch_q;
  assign vec_count = vec_count_q;
  assign err_count = err_count_q;

endmodule
